// File: rtl/vram_pkg.sv
// Shared constants and fill-state encoding for the text-mode video RAM arbiter.
package vram_pkg;

    localparam int unsigned ADDR_W       = 12;
    localparam int unsigned DATA_W       = 16;
    localparam int unsigned CELLS        = 80 * 25;
    localparam logic [15:0] FILL_DEFAULT = 16'h0700;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_FILL = 2'd2
    } vram_state_e;

endpackage

// File: rtl/vram_fill_engine.sv
// Fill address counter and latched fill word; the counter stops at CELLS-1
// and only a new start returns it to 0.
module vram_fill_engine #(
    parameter int unsigned       ADDR_W       = vram_pkg::ADDR_W,
    parameter int unsigned       DATA_W       = vram_pkg::DATA_W,
    parameter int unsigned       CELLS        = vram_pkg::CELLS,
    parameter logic [DATA_W-1:0] FILL_DEFAULT = DATA_W'(vram_pkg::FILL_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] start_word,
    input  logic              advance,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] word,
    output logic              last
);

    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_word;
    logic              w_last;

    assign w_last = (32'(r_addr) == CELLS - 1);

    // Reset reloads the power-on word so the following INIT pass clears the screen.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= '0;
            r_word <= FILL_DEFAULT;
        end else if (start) begin
            r_addr <= '0;
            r_word <= start_word;
        end else if (advance && !w_last) begin
            r_addr <= r_addr + 1'b1;
        end
    end

    assign addr = r_addr;
    assign word = r_word;
    assign last = w_last;

endmodule

// File: rtl/vram_arbiter.sv
// Arbitrates CPU cell writes against a whole-screen fill engine onto one VRAM
// write port. Fill engine compiled in only when VRAM_ARBITER_FILL_EN is defined.
module vram_arbiter #(
    parameter int unsigned       ADDR_W       = vram_pkg::ADDR_W,
    parameter int unsigned       DATA_W       = vram_pkg::DATA_W,
    parameter int unsigned       CELLS        = vram_pkg::CELLS,
    parameter logic [DATA_W-1:0] FILL_DEFAULT = DATA_W'(vram_pkg::FILL_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    output logic              cpu_ack,
    input  logic              fill_start,
    input  logic [DATA_W-1:0] fill_word,
    output logic              fill_busy,
    output logic              fill_done,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [DATA_W-1:0] vram_data,
    output logic              vram_we
);

    import vram_pkg::*;

    logic              r_cpu_ack;
    logic              r_vram_we;
    logic [ADDR_W-1:0] r_vram_addr;
    logic [DATA_W-1:0] r_vram_data;

    logic              w_cpu_elig;
    logic              w_cpu_in_range;
    logic              w_cpu_grant;
    logic              w_fill_grant;
    logic [ADDR_W-1:0] w_fill_addr;
    logic [DATA_W-1:0] w_fill_word;

    // The CPU sits out the cycle its ack is showing, capping it at one write per 2 cycles.
    assign w_cpu_elig     = cpu_req && !r_cpu_ack;
    assign w_cpu_in_range = (32'(cpu_addr) < CELLS);

`ifdef VRAM_ARBITER_FILL_EN
    vram_state_e r_state;
    logic        r_fill_prio;
    logic        r_fill_busy;
    logic        r_fill_done;
    logic        w_fill_active;
    logic        w_fill_start;
    logic        w_fill_last;

    assign w_fill_active = (r_state != ST_IDLE);
    assign w_fill_start  = (r_state == ST_IDLE) && fill_start;

    always_comb begin
        w_cpu_grant  = 1'b0;
        w_fill_grant = 1'b0;
        if (w_cpu_elig && w_fill_active) begin
            if (r_fill_prio) begin
                w_fill_grant = 1'b1;
            end else begin
                w_cpu_grant = 1'b1;
            end
        end else begin
            w_cpu_grant  = w_cpu_elig;
            w_fill_grant = w_fill_active;
        end
    end

    vram_fill_engine #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .CELLS        (CELLS),
        .FILL_DEFAULT (FILL_DEFAULT)
    ) u_fill_engine (
        .clk        (clk),
        .rst        (rst),
        .start      (w_fill_start),
        .start_word (fill_word),
        .advance    (w_fill_grant),
        .addr       (w_fill_addr),
        .word       (w_fill_word),
        .last       (w_fill_last)
    );

    // Priority flips on every grant so a CPU holding req interleaves one-for-one
    // with the fill; a new fill always offers the CPU the first contended slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_INIT;
            r_fill_prio <= 1'b0;
            r_fill_busy <= 1'b1;
            r_fill_done <= 1'b0;
        end else begin
            r_fill_done <= 1'b0;
            if (w_fill_grant) begin
                r_fill_prio <= 1'b0;
            end else if (w_cpu_grant) begin
                r_fill_prio <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (fill_start) begin
                        r_state     <= ST_FILL;
                        r_fill_busy <= 1'b1;
                        r_fill_prio <= 1'b0;
                    end
                end
                default: begin
                    if (w_fill_grant && w_fill_last) begin
                        r_state     <= ST_IDLE;
                        r_fill_busy <= 1'b0;
                        r_fill_done <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign fill_busy = r_fill_busy;
    assign fill_done = r_fill_done;
`else
    logic w_unused;

    assign w_cpu_grant  = w_cpu_elig;
    assign w_fill_grant = 1'b0;
    assign w_fill_addr  = '0;
    assign w_fill_word  = '0;
    assign fill_busy    = 1'b0;
    assign fill_done    = 1'b0;
    assign w_unused     = ^{fill_start, fill_word};
`endif

    // Out-of-range CPU writes are acked but leave the VRAM port holding its last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cpu_ack   <= 1'b0;
            r_vram_we   <= 1'b0;
            r_vram_addr <= '0;
            r_vram_data <= '0;
        end else begin
            r_cpu_ack <= w_cpu_grant;
            r_vram_we <= 1'b0;
            if (w_fill_grant) begin
                r_vram_we   <= 1'b1;
                r_vram_addr <= w_fill_addr;
                r_vram_data <= w_fill_word;
            end else if (w_cpu_grant && w_cpu_in_range) begin
                r_vram_we   <= 1'b1;
                r_vram_addr <= cpu_addr;
                r_vram_data <= cpu_data;
            end
        end
    end

    assign cpu_ack   = r_cpu_ack;
    assign vram_we   = r_vram_we;
    assign vram_addr = r_vram_addr;
    assign vram_data = r_vram_data;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter; covers the fill build when
// VRAM_ARBITER_FILL_EN is defined, otherwise the CPU-only build.
module tb_vram_arbiter;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 16;
    localparam int unsigned NC = 2000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cpu_req = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_data = '0;
    logic          cpu_ack;
    logic          fill_start = 1'b0;
    logic [DW-1:0] fill_word = '0;
    logic          fill_busy;
    logic          fill_done;
    logic [AW-1:0] vram_addr;
    logic [DW-1:0] vram_data;
    logic          vram_we;

    always #5 clk = ~clk;

    vram_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .CELLS        (NC),
        .FILL_DEFAULT (16'h0700)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_data   (cpu_data),
        .cpu_ack    (cpu_ack),
        .fill_start (fill_start),
        .fill_word  (fill_word),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done),
        .vram_addr  (vram_addr),
        .vram_data  (vram_data),
        .vram_we    (vram_we)
    );

    typedef struct {
        bit            is_fill;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          ack;
        logic          done;
        int            id;
    } exp_t;

    exp_t          exp_q[$];
    int            n_vec = 0;
    int            n_miss = 0;
    int            n_id = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;

    // Expected port contents: a dropped write leaves address/data at the last real write.
    function automatic void push(input bit is_fill, input bit we, input logic [AW-1:0] a,
                                 input logic [DW-1:0] d, input bit ack, input bit done);
        exp_t e;
        if (we) begin
            m_addr = a;
            m_data = d;
        end
        e.is_fill = is_fill;
        e.we      = we;
        e.addr    = m_addr;
        e.data    = m_data;
        e.ack     = ack;
        e.done    = done;
        e.id      = n_id;
        n_id++;
        exp_q.push_back(e);
    endfunction

    function automatic void push_cpu(input logic [AW-1:0] a, input logic [DW-1:0] d);
        push(1'b0, (32'(a) < NC), a, d, 1'b1, 1'b0);
    endfunction

    function automatic void push_fill(input int a, input logic [DW-1:0] d);
        push(1'b1, 1'b1, AW'(a), d, 1'b0, (a == NC - 1));
    endfunction

    always @(negedge clk) begin
        if (!rst && (vram_we || cpu_ack || fill_done)) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_miss++;
                $display("FAIL unexpected_output: got we=%0b addr=%0d data=%h ack=%0b done=%0b, required no activity",
                         vram_we, vram_addr, vram_data, cpu_ack, fill_done);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({vram_we, vram_addr, vram_data, cpu_ack, fill_done} !==
                    {e.we, e.addr, e.data, e.ack, e.done}) begin
                    n_miss++;
                    $display("FAIL %s#%0d: got we=%0b addr=%0d data=%h ack=%0b done=%0b, required we=%0b addr=%0d data=%h ack=%0b done=%0b",
                             e.is_fill ? "fill_write" : "cpu_write", e.id,
                             vram_we, vram_addr, vram_data, cpu_ack, fill_done,
                             e.we, e.addr, e.data, e.ack, e.done);
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_miss++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    // Single CPU write issued at a negedge; returns one idle cycle after the ack.
    task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int lat;
        push_cpu(a, d);
        cpu_req  = 1'b1;
        cpu_addr = a;
        cpu_data = d;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!cpu_ack && lat < 20);
        cpu_req = 1'b0;
        chk("cpu_ack_latency", lat, 1);
        @(negedge clk);
    endtask

    // CPU keeps req high across n writes, moving to the next word after each ack.
    task automatic cpu_burst(input int base, input int n, input bit do_push, output int cyc);
        int w;
        cyc = 0;
        if (do_push) begin
            for (int j = 0; j < n; j++) push_cpu(AW'(base + j), DW'(32'h4100 + j));
        end
        cpu_req  = 1'b1;
        cpu_addr = AW'(base);
        cpu_data = DW'(32'h4100);
        for (int j = 0; j < n; j++) begin
            w = 0;
            do begin
                @(negedge clk);
                cyc++;
                w++;
            end while (!cpu_ack && w < 20);
            if (j + 1 < n) begin
                cpu_addr = AW'(base + j + 1);
                cpu_data = DW'(32'h4100 + j + 1);
            end
        end
        cpu_req = 1'b0;
    endtask

    task automatic wait_done(input string nm, output int cyc);
        cyc = 0;
        for (int k = 0; k < 2200; k++) begin
            @(negedge clk);
            cyc++;
            if (fill_done) break;
        end
        if (!fill_done) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s: got no fill_done within %0d cycles, required fill_done", nm, cyc);
        end
    endtask

    task automatic chk_reset_outputs(input int busy_req);
        chk("rst_vram_we", vram_we, 0);
        chk("rst_vram_addr", vram_addr, 0);
        chk("rst_vram_data", vram_data, 0);
        chk("rst_cpu_ack", cpu_ack, 0);
        chk("rst_fill_done", fill_done, 0);
        chk("rst_fill_busy", fill_busy, busy_req);
    endtask

    initial begin
        int cyc;
        int found;
        repeat (3) @(negedge clk);
`ifdef VRAM_ARBITER_FILL_EN
        chk_reset_outputs(1);
        for (int a = 0; a < NC; a++) push_fill(a, 16'h0700);
        rst = 1'b0;
        wait_done("init_fill", cyc);
        chk("init_fill_cycles", cyc, NC);
        chk("init_busy_drop", fill_busy, 0);
        @(negedge clk);

        cpu_write(12'd5, 16'h0748);
        cpu_write(12'd2000, 16'hBEEF);

        for (int a = 0; a < NC; a++) push_fill(a, 16'h1F20);
        fill_start = 1'b1;
        fill_word  = 16'h1F20;
        @(negedge clk);
        fill_start = 1'b0;
        fill_word  = 16'hFFFF;
        chk("fill_busy_rise", fill_busy, 1);
        repeat (500) @(negedge clk);
        fill_start = 1'b1;
        fill_word  = 16'h0000;
        @(negedge clk);
        fill_start = 1'b0;
        wait_done("user_fill", cyc);
        chk("fill_busy_drop", fill_busy, 0);
        @(negedge clk);

        for (int a = 0; a < 1000; a++) push(1'b1, 1'b1, AW'(a), 16'h2A55, 1'b0, 1'b0);
        fill_start = 1'b1;
        fill_word  = 16'h2A55;
        @(negedge clk);
        fill_start = 1'b0;
        found = 0;
        for (int k = 0; k < 1100 && found == 0; k++) begin
            if (vram_we && vram_addr == 12'd999) found = 1;
            else @(negedge clk);
        end
        chk("abort_point_reached", found, 1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_outputs(1);
        chk("abort_queue_drained", exp_q.size(), 0);

        for (int j = 0; j < 10; j++) begin
            push_cpu(AW'(100 + j), DW'(32'h4100 + j));
            push_fill(j, 16'h0700);
        end
        for (int a = 10; a < NC; a++) push_fill(a, 16'h0700);
        rst = 1'b0;
        cpu_burst(100, 10, 1'b0, cyc);
        chk("contended_cpu_cycles", cyc, 19);
        wait_done("reinit_fill", cyc);
        chk("reinit_busy_drop", fill_busy, 0);
`else
        chk_reset_outputs(0);
        rst = 1'b0;
        @(negedge clk);
        fill_start = 1'b1;
        fill_word  = 16'h1F20;
        @(negedge clk);
        fill_start = 1'b0;
        repeat (5) @(negedge clk);
        chk("nofill_busy", fill_busy, 0);
        chk("nofill_done", fill_done, 0);

        cpu_write(12'd5, 16'h0748);
        cpu_write(12'd2000, 16'hBEEF);
        cpu_write(12'd1999, 16'h1234);
        cpu_write(12'd4095, 16'hFFFF);
        cpu_write(12'd0, 16'hABCD);
        cpu_burst(200, 4, 1'b1, cyc);
        chk("held_req_cycles", cyc, 7);
`endif
        repeat (5) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, video RAM address width.
REQ-002 Parameter DATA_W, default 16, video RAM cell width: attribute in [15:8], character in [7:0].
REQ-003 Parameter CELLS, default 2000 (80x25), number of valid text cells.
REQ-004 Parameter FILL_DEFAULT, default 16'h0700, word written by the power-on fill.
REQ-005 clk  in  1  single system clock; all logic on posedge clk.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 cpu_req  in  1  CPU write request; held until cpu_ack.
REQ-008 cpu_addr  in  ADDR_W  CPU target cell address.
REQ-009 cpu_data  in  DATA_W  CPU write word.
REQ-010 cpu_ack  out  1  one-cycle pulse; CPU write accepted.
REQ-011 fill_start  in  1  one-cycle pulse; start a whole-screen fill.
REQ-012 fill_word  in  DATA_W  fill value, sampled on an accepted fill_start.
REQ-013 fill_busy  out  1  high while a fill is in progress.
REQ-014 fill_done  out  1  one-cycle pulse after the last fill write.
REQ-015 vram_addr  out  ADDR_W  video RAM write address.
REQ-016 vram_data  out  DATA_W  video RAM write data.
REQ-017 vram_we  out  1  video RAM write enable, one cycle per write.

Function
REQ-018 All outputs SHALL be registered; a write granted in cycle N SHALL appear on vram_* in cycle N+1.
REQ-019 The CPU is eligible for grant in cycle N only when cpu_req=1 and cpu_ack=0; cpu_ack SHALL pulse in cycle N+1 alongside the write, so CPU throughput is at most one write per 2 cycles.
REQ-020 A CPU write with cpu_addr >= CELLS SHALL be acked with vram_we=0 (dropped).
REQ-021 States: INIT, IDLE, FILL. INIT and FILL step a counter from 0 to CELLS-1, one eligible write per grant.
REQ-022 INIT SHALL write FILL_DEFAULT; FILL SHALL write the latched fill_word.
REQ-023 IDLE->FILL on fill_start; fill_start in INIT or FILL SHALL be ignored, with fill_word not re-latched.
REQ-024 When the write at address CELLS-1 is granted, go to IDLE; fill_done SHALL pulse in the cycle that write appears on vram_*; fill_busy SHALL drop in the same cycle.
REQ-025 fill_busy SHALL be high throughout INIT and FILL.
REQ-026 When the CPU and the fill engine are both eligible, grants SHALL alternate; the first contended grant goes to the CPU.
REQ-027 An uncontended requester SHALL be granted every eligible cycle; the fill counter SHALL never wrap past CELLS-1.
REQ-028 When no write is granted, vram_we SHALL be 0 and vram_addr/vram_data SHALL hold their last values.

Reset
REQ-029 On rst, in the same clock edge: vram_addr=0, vram_data=0, vram_we=0, cpu_ack=0, fill_done=0, fill counter=0, contention pointer=CPU.
REQ-030 After rst deasserts, the block SHALL enter INIT with fill_busy=1 (power-on clear).
REQ-031 rst during INIT or FILL SHALL abort the fill with no fill_done; the post-reset INIT SHALL restart at address 0.

Configuration
REQ-032 Macro VRAM_ARBITER_FILL_EN defined: fill engine, INIT/FILL states and the arbitration of REQ-026 are compiled in.
REQ-033 Macro absent: no fill engine; fill_busy=0 and fill_done=0 permanently; fill_start and fill_word are ignored; no power-on clear; after reset the CPU is granted whenever eligible.

Structure
REQ-034 Shared package vram_pkg SHALL hold ADDR_W, DATA_W, CELLS (80*25), FILL_DEFAULT and the INIT/IDLE/FILL state enum.
REQ-035 The address counter and latched fill word SHALL be a sub-module vram_fill_engine (start, advance, addr, word, last); vram_arbiter owns grant logic and output registers.

Verification
REQ-036 Release rst, no CPU traffic -> 2000 writes of 16'h0700 at addresses 0..1999 on consecutive cycles; fill_done pulses once, with the write to 1999.
REQ-037 In IDLE, cpu_req with addr=5, data=16'h0748 -> one cycle later: vram_we=1, vram_addr=5, vram_data=16'h0748, cpu_ack=1.
REQ-038 CPU holds cpu_req continuously during INIT -> grants alternate CPU, fill, CPU, fill...; INIT completes and every CPU write is acked exactly once.
REQ-039 cpu_addr=2000 -> cpu_ack pulses, vram_we stays 0.
REQ-040 fill_start with fill_word=16'h1F20, then a second fill_start with 16'h0000 mid-fill -> all 2000 cells are written 16'h1F20.
REQ-041 rst asserted at fill address 1000 -> no fill_done; INIT restarts at address 0 after release.
